dmem_arbiter: RTL

- Sequences the single-port Data_Memory and shares it between two requesters: the CPU MEM stage (port C) and a test/loader DMA port (port D).
- Sits between the pipeline's MEM stage and Data_Memory, and turns a multi-cycle memory into a stall request for the hazard unit.
- Port C has fixed priority. A starvation counter guarantees port D progress.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arb_sel.sv | 39 +++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, requester ids
// and address word alignment.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Wide enough for any ADDR_W in use; callers cast to and from their own width.
  localparam int ALIGN_W = 64;

  function automatic logic [ALIGN_W-1:0] word_align(input logic [ALIGN_W-1:0] addr);
    return {addr[ALIGN_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_arb_sel.sv
// Winner select between the CPU port and the DMA port. The CPU port has fixed priority,
// and a starvation counter hands the memory to the DMA port after STARVE_MAX CPU grants.
module dmem_arb_sel
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic grant_i,
  output logic winner_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  always_comb begin
    winner_o = PORT_C;
    if (!cpu_req_i) winner_o = PORT_D;
    else if (dma_req_i && (starve_cnt == SMAX)) winner_o = PORT_D;
  end

  // The count only measures an unbroken wait, so it clears whenever D stops asking.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      starve_cnt <= '0;
    end else if (!dma_req_i) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      if (winner_o == PORT_D) starve_cnt <= '0;
      else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences the single-port data memory for the CPU MEM stage and the DMA/loader port.
// Each access takes MEM_LAT busy cycles plus a one-cycle ack; the CPU sees a stall meanwhile.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              addr_err_o,
  output logic              busy_o,
  output dmem_state_t       state_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  // Handshake: a requester raises req with we/addr/wdata and holds req until its ack
  // pulse; the request fields are sampled only at the grant edge in IDLE. Req must drop
  // by the edge that ends the ack cycle, otherwise it is taken as a new access.
  dmem_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              win_id, win_we, grant, last_beat;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              lat_id, lat_we, lat_misalign;

  dmem_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .cpu_req_i(cpu_req_i),
    .dma_req_i(dma_req_i),
    .grant_i  (grant),
    .winner_o (win_id)
  );

  assign grant     = (state == IDLE) && (cpu_req_i || dma_req_i);
  assign last_beat = (state == BUSY) && (cnt == CNT_LAST);
  assign win_we    = (win_id == PORT_D) ? dma_we_i    : cpu_we_i;
  assign win_addr  = (win_id == PORT_D) ? dma_addr_i  : cpu_addr_i;
  assign win_wdata = (win_id == PORT_D) ? dma_wdata_i : cpu_wdata_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = BUSY;
      BUSY:    if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt          <= '0;
      lat_id       <= PORT_C;
      lat_we       <= 1'b0;
      lat_misalign <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cpu_rdata_o  <= '0;
      dma_rdata_o  <= '0;
    end else begin
      if (grant) begin
        lat_id       <= win_id;
        lat_we       <= win_we;
        lat_misalign <= (win_addr[1:0] != 2'b00);
        mem_addr_o   <= ADDR_W'(word_align(ALIGN_W'(win_addr)));
        mem_wdata_o  <= win_wdata;
        cnt          <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (last_beat && !lat_we) begin
        if (lat_id == PORT_C) cpu_rdata_o <= mem_rdata_i;
        else                  dma_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign mem_en_o    = (state == BUSY);
  assign mem_we_o    = lat_we && last_beat;
  assign cpu_ack_o   = (state == DONE) && (lat_id == PORT_C);
  assign dma_ack_o   = (state == DONE) && (lat_id == PORT_D);
  assign addr_err_o  = (state == DONE) && lat_misalign;
  assign cpu_stall_o = cpu_req_i && !cpu_ack_o;
  assign busy_o      = (state != IDLE);
  assign state_o     = state;

endmodule
